fetch_flush_controller: RTL and testbench

FETCH_FLUSH_CONTROLLER -- requirements
Module: fetch_flush_controller

---
 rtl/fetch_flush_controller.sv | 142 ++++++++++++++
 tb/tb_fetch_flush_controller.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_flush_controller.sv
// Fetch flush/redirect controller.
// Arbitrates trap, branch-mispredict, ITLB-miss, I-cache-miss and
// instruction-buffer-full events into a single registered flush pulse and
// stalls fetch until the miss or full condition resolves.
// Optional feature: define RAFI_FETCH_STALL_COUNTER_EN to build the 32-bit
// stall cycle counter; without it stallCycles is tied to zero.
module fetch_flush_controller #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trapValid,
   input  logic [ADDR_WIDTH-1:0] trapVector,
   input  logic                  branchValid,
   input  logic [ADDR_WIDTH-1:0] branchTarget,
   input  logic                  itlbMissValid,
   input  logic [ADDR_WIDTH-1:0] itlbMissPc,
   input  logic                  itlbRefillDone,
   input  logic                  icacheMissValid,
   input  logic [ADDR_WIDTH-1:0] icacheMissPc,
   input  logic                  icacheRefillDone,
   input  logic                  bufferFullValid,
   input  logic [ADDR_WIDTH-1:0] bufferFullPc,
   input  logic                  bufferHasSpace,
   output logic                  flushValid,
   output logic [2:0]            flushReason,
   output logic [ADDR_WIDTH-1:0] flushPc,
   output logic                  fetchStall,
   output logic [31:0]           stallCycles
);

   typedef logic [ADDR_WIDTH-1:0] vaddr_t;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ITLB   = 2'd1,
      WAIT_ICACHE = 2'd2,
      WAIT_BUFFER = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      RSN_NONE         = 3'h0,
      RSN_BRANCH       = 3'h1,
      RSN_TRAP         = 3'h2,
      RSN_ITLB_MISS    = 3'h4,
      RSN_ICACHE_MISS  = 3'h5,
      RSN_BUFFER_FULL  = 3'h6
   } flush_reason_e;

   state_e        state_q, state_d;
   logic          flush_valid_q, flush_valid_d;
   flush_reason_e flush_reason_q, flush_reason_d;
   vaddr_t        flush_pc_q, flush_pc_d;

   // Next-state and flush selection: trap/branch win everywhere, misses only from IDLE.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d        = state_q;
      flush_valid_d  = 1'b0;
      flush_reason_d = RSN_NONE;
      flush_pc_d     = flush_pc_q;

      if (trapValid) begin
         flush_valid_d  = 1'b1;
         flush_reason_d = RSN_TRAP;
         flush_pc_d     = trapVector;
         state_d        = IDLE;
      end else if (branchValid) begin
         flush_valid_d  = 1'b1;
         flush_reason_d = RSN_BRANCH;
         flush_pc_d     = branchTarget;
         state_d        = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (itlbMissValid) begin
                  flush_valid_d  = 1'b1;
                  flush_reason_d = RSN_ITLB_MISS;
                  flush_pc_d     = itlbMissPc;
                  state_d        = WAIT_ITLB;
               end else if (icacheMissValid) begin
                  flush_valid_d  = 1'b1;
                  flush_reason_d = RSN_ICACHE_MISS;
                  flush_pc_d     = icacheMissPc;
                  state_d        = WAIT_ICACHE;
               end else if (bufferFullValid) begin
                  flush_valid_d  = 1'b1;
                  flush_reason_d = RSN_BUFFER_FULL;
                  flush_pc_d     = bufferFullPc;
                  state_d        = WAIT_BUFFER;
               end
            end
            // Wait states only listen for their own release; fetch resumes at flushPc silently.
            WAIT_ITLB:   if (itlbRefillDone)   state_d = IDLE;
            WAIT_ICACHE: if (icacheRefillDone) state_d = IDLE;
            WAIT_BUFFER: if (bufferHasSpace)   state_d = IDLE;
            default:     state_d = IDLE;
         endcase
      end
   end

   // State and registered flush outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: every control register is reset, and flush_pc_q to RESET_PC, so fetch restarts from a known PC.
         state_q        <= IDLE;
         flush_valid_q  <= 1'b0;
         flush_reason_q <= RSN_NONE;
         flush_pc_q     <= RESET_PC;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q        <= state_d;
         flush_valid_q  <= flush_valid_d;
         flush_reason_q <= flush_reason_d;
         flush_pc_q     <= flush_pc_d;
      end
   end

   assign flushValid  = flush_valid_q;
   assign flushReason = flush_reason_q;
   assign flushPc     = flush_pc_q;
   assign fetchStall  = (state_q != IDLE);

`ifdef RAFI_FETCH_STALL_COUNTER_EN
   logic [31:0] stall_cnt_q;

   // Count every cycle fetch is stalled; wraps naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
      end else if (fetchStall) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stallCycles = stall_cnt_q;
`else
   assign stallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_flush_controller.sv
// Testbench for fetch_flush_controller: directed scenarios plus a randomized
// run against a behavioural model built from the flush/stall rules.
module tb_fetch_flush_controller;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef RAFI_FETCH_STALL_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trapValid, branchValid, itlbMissValid, itlbRefillDone;
   logic        icacheMissValid, icacheRefillDone, bufferFullValid, bufferHasSpace;
   logic [31:0] trapVector, branchTarget, itlbMissPc, icacheMissPc, bufferFullPc;
   logic        flushValid, fetchStall;
   logic [2:0]  flushReason;
   logic [31:0] flushPc, stallCycles;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: what fetch is waiting for ("" = nothing) plus output expectations.
   string       m_wait;
   logic        m_fv;
   logic [2:0]  m_reason;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   fetch_flush_controller dut (
      .clk(clk), .rst(rst),
      .trapValid(trapValid), .trapVector(trapVector),
      .branchValid(branchValid), .branchTarget(branchTarget),
      .itlbMissValid(itlbMissValid), .itlbMissPc(itlbMissPc), .itlbRefillDone(itlbRefillDone),
      .icacheMissValid(icacheMissValid), .icacheMissPc(icacheMissPc), .icacheRefillDone(icacheRefillDone),
      .bufferFullValid(bufferFullValid), .bufferFullPc(bufferFullPc), .bufferHasSpace(bufferHasSpace),
      .flushValid(flushValid), .flushReason(flushReason), .flushPc(flushPc),
      .fetchStall(fetchStall), .stallCycles(stallCycles)
   );

   function automatic logic [68:0] obs();
      return {flushValid, flushReason, flushPc, fetchStall, stallCycles};
   endfunction

   function automatic logic [31:0] cnt(input int n);
      return CNT_EN ? 32'(n) : 32'd0;
   endfunction

   task automatic clear_inputs();
      trapValid = 0; branchValid = 0; itlbMissValid = 0; itlbRefillDone = 0;
      icacheMissValid = 0; icacheRefillDone = 0; bufferFullValid = 0; bufferHasSpace = 1;
      trapVector = 0; branchTarget = 0; itlbMissPc = 0; icacheMissPc = 0; bufferFullPc = 0;
   endtask

   // One clock edge as seen by the model: flush rules and wait release from the requirements.
   task automatic model_edge();
      m_fv = 0;
      m_reason = 3'h0;
      if (m_wait != "") m_cnt = m_cnt + 1;
      if (trapValid) begin
         m_fv = 1; m_reason = 3'h2; m_pc = trapVector; m_wait = "";
      end else if (branchValid) begin
         m_fv = 1; m_reason = 3'h1; m_pc = branchTarget; m_wait = "";
      end else if (m_wait == "") begin
         if (itlbMissValid) begin
            m_fv = 1; m_reason = 3'h4; m_pc = itlbMissPc; m_wait = "itlb";
         end else if (icacheMissValid) begin
            m_fv = 1; m_reason = 3'h5; m_pc = icacheMissPc; m_wait = "icache";
         end else if (bufferFullValid) begin
            m_fv = 1; m_reason = 3'h6; m_pc = bufferFullPc; m_wait = "buffer";
         end
      end else if ((m_wait == "itlb" && itlbRefillDone) ||
                   (m_wait == "icache" && icacheRefillDone) ||
                   (m_wait == "buffer" && bufferHasSpace)) begin
         m_wait = "";
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      m_wait = ""; m_fv = 0; m_reason = 3'h0; m_pc = RESET_PC; m_cnt = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic test_reset();
      logic [68:0] exp_v;
      clear_inputs();
      rst = 1;
      branchValid = 1; branchTarget = 32'h8000_0ABC;
      icacheMissValid = 1; icacheMissPc = 32'h8000_0DEF;
      @(posedge clk); @(posedge clk); #1;
      exp_v = {1'b0, 3'h0, RESET_PC, 1'b0, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL reset_hold: got %h expected %h", obs(), exp_v);
      end
      clear_inputs();
      rst = 0;
      tick();
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL reset_release_no_flush: got %h expected %h", obs(), exp_v);
      end
   endtask

   task automatic test_branch();
      logic [68:0] exp_v;
      do_reset();
      branchValid = 1; branchTarget = 32'h8000_0100;
      tick();
      clear_inputs();
      exp_v = {1'b1, 3'h1, 32'h8000_0100, 1'b0, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL branch_flush: got %h expected %h", obs(), exp_v);
      end
      tick();
      exp_v = {1'b0, 3'h0, 32'h8000_0100, 1'b0, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL branch_one_cycle_pc_hold: got %h expected %h", obs(), exp_v);
      end
   endtask

   task automatic test_icache_miss();
      logic [68:0] exp_v;
      do_reset();
      icacheMissValid = 1; icacheMissPc = 32'h8000_0040;
      tick();
      clear_inputs();
      exp_v = {1'b1, 3'h5, 32'h8000_0040, 1'b1, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL icache_flush: got %h expected %h", obs(), exp_v);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp_v = {1'b0, 3'h0, 32'h8000_0040, 1'b1, cnt(i)};
         checks++;
         if (obs() !== exp_v) begin
            failures++;
            $display("FAIL icache_stall_cycle%0d: got %h expected %h", i, obs(), exp_v);
         end
      end
      icacheRefillDone = 1;
      tick();
      clear_inputs();
      exp_v = {1'b0, 3'h0, 32'h8000_0040, 1'b0, cnt(5)};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL icache_release: got %h expected %h", obs(), exp_v);
      end
   endtask

   task automatic test_priority();
      logic [68:0] exp_v;
      do_reset();
      trapValid = 1; trapVector = 32'h8000_0004;
      branchValid = 1; branchTarget = 32'h8000_0999;
      itlbMissValid = 1; itlbMissPc = 32'h8000_0888;
      tick();
      clear_inputs();
      exp_v = {1'b1, 3'h2, 32'h8000_0004, 1'b0, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL priority_trap_wins: got %h expected %h", obs(), exp_v);
      end
      tick();
      exp_v = {1'b0, 3'h0, 32'h8000_0004, 1'b0, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL priority_single_flush: got %h expected %h", obs(), exp_v);
      end
   endtask

   task automatic test_itlb_branch_override();
      logic [68:0] exp_v;
      do_reset();
      itlbMissValid = 1; itlbMissPc = 32'h8000_0300;
      tick();
      clear_inputs();
      exp_v = {1'b1, 3'h4, 32'h8000_0300, 1'b1, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL itlb_flush: got %h expected %h", obs(), exp_v);
      end
      icacheRefillDone = 1;   // not the awaited refill: must be ignored
      tick();
      clear_inputs();
      exp_v = {1'b0, 3'h0, 32'h8000_0300, 1'b1, cnt(1)};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL itlb_wrong_refill_ignored: got %h expected %h", obs(), exp_v);
      end
      itlbRefillDone = 1; branchValid = 1; branchTarget = 32'h8000_0200;
      tick();
      clear_inputs();
      exp_v = {1'b1, 3'h1, 32'h8000_0200, 1'b0, cnt(2)};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL itlb_branch_override: got %h expected %h", obs(), exp_v);
      end
   endtask

   task automatic test_buffer_full();
      logic [68:0] exp_v;
      do_reset();
      bufferFullValid = 1; bufferFullPc = 32'h8000_0010; bufferHasSpace = 0;
      tick();
      bufferFullValid = 0;
      icacheMissValid = 1; icacheMissPc = 32'h8000_0777;
      exp_v = {1'b1, 3'h6, 32'h8000_0010, 1'b1, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL buffer_flush: got %h expected %h", obs(), exp_v);
      end
      for (int i = 1; i <= 2; i++) begin
         tick();
         exp_v = {1'b0, 3'h0, 32'h8000_0010, 1'b1, cnt(i)};
         checks++;
         if (obs() !== exp_v) begin
            failures++;
            $display("FAIL buffer_wait_cycle%0d: got %h expected %h", i, obs(), exp_v);
         end
      end
      icacheMissValid = 0;
      bufferHasSpace = 1;
      tick();
      clear_inputs();
      exp_v = {1'b0, 3'h0, 32'h8000_0010, 1'b0, cnt(3)};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL buffer_release: got %h expected %h", obs(), exp_v);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [68:0] exp_v;
      do_reset();
      icacheMissValid = 1; icacheMissPc = 32'h8000_0040;
      tick();
      clear_inputs();
      tick();
      #2;
      rst = 1;
      icacheMissValid = 1; icacheMissPc = 32'h8000_0444;
      #1;
      exp_v = {1'b0, 3'h0, RESET_PC, 1'b0, 32'd0};
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL reset_async_mid_wait: got %h expected %h", obs(), exp_v);
      end
      @(posedge clk); #1;
      clear_inputs();
      rst = 0;
      m_wait = ""; m_fv = 0; m_reason = 3'h0; m_pc = RESET_PC; m_cnt = 0;
      tick();
      checks++;
      if (obs() !== exp_v) begin
         failures++;
         $display("FAIL reset_no_flush_after_release: got %h expected %h", obs(), exp_v);
      end
   endtask

   task automatic test_random();
      logic [68:0] exp_v;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         trapValid        = ($urandom_range(15) == 0);
         branchValid      = ($urandom_range(9) == 0);
         itlbMissValid    = ($urandom_range(5) == 0);
         icacheMissValid  = ($urandom_range(4) == 0);
         bufferFullValid  = ($urandom_range(4) == 0);
         itlbRefillDone   = ($urandom_range(4) == 0);
         icacheRefillDone = ($urandom_range(4) == 0);
         bufferHasSpace   = ($urandom_range(2) == 0);
         trapVector   = $urandom();
         branchTarget = $urandom();
         itlbMissPc   = $urandom();
         icacheMissPc = $urandom();
         bufferFullPc = $urandom();
         tick();
         exp_v = {m_fv, m_reason, m_pc, (m_wait != ""), CNT_EN ? m_cnt : 32'd0};
         checks++;
         if (obs() !== exp_v) begin
            failures++;
            $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), exp_v);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      m_wait = ""; m_fv = 0; m_reason = 3'h0; m_pc = RESET_PC; m_cnt = 0;
      test_reset();
      test_branch();
      test_icache_miss();
      test_priority();
      test_itlb_branch_override();
      test_buffer_full();
      test_reset_mid_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
